list_loader: RTL and testbench

LIST_LOADER -- requirements
Module: list_loader

---
 rtl/aoc_pkg.sv | 18 +
 rtl/list_loader_if.sv | 43 ++++
 rtl/list_loader.sv | 126 ++++++++++++
 tb/tb_list_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aoc_pkg
// Purpose  : Shared loader/consumer types: FSM state enum and default width.
// Revision : 1.0
// ============================================================================
package aoc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEFAULT = 32;

endpackage
`default_nettype wire

// File: rtl/list_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : list_loader_if
// Purpose  : Pair-stream input, control/status and dual write-port bundle.
// Revision : 1.0
// ============================================================================
interface list_loader_if
  import aoc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

  logic              go;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_last;
  logic [31:0]       addr1;
  logic [31:0]       addr2;
  logic [DATA_W-1:0] data1_in;
  logic [DATA_W-1:0] data2_in;
  logic              we1;
  logic              we2;
  logic [15:0]       length;
  logic              overflow;
  logic [31:0]       checksum;

  modport master (
    output go, in_valid, in_a, in_b, in_last,
    input  done, in_ready, addr1, addr2, data1_in, data2_in,
           we1, we2, length, overflow, checksum
  );

  modport slave (
    input  go, in_valid, in_a, in_b, in_last,
    output done, in_ready, addr1, addr2, data1_in, data2_in,
           we1, we2, length, overflow, checksum
  );

endinterface
`default_nettype wire

// File: rtl/list_loader.sv
`default_nettype none
// ============================================================================
// Module   : list_loader
// Purpose  : Streams (a,b) pairs into two list memories, reports length.
//            Optional XOR checksum enabled by LIST_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module list_loader
  import aoc_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  wire logic    clk,
  input  wire logic    reset,
  list_loader_if.slave bus
);

  localparam logic [1:0]  c_st_idle  = IDLE;
  localparam logic [1:0]  c_st_load  = LOAD;
  localparam logic [1:0]  c_st_done  = DONE;
  // 17-bit index so that DEPTH = 65536 is representable as the full mark.
  localparam logic [16:0] c_depth    = 17'(DEPTH);
  localparam logic [16:0] c_last_idx = 17'(DEPTH - 1);

  logic [1:0]        r_state;
  logic [16:0]       r_index;
  logic              r_done;
  logic              r_we;
  logic [16:0]       r_addr;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic [15:0]       r_length;
  logic              r_overflow;

  logic w_ready;
  logic w_accept;
  logic w_start;

  assign w_ready  = (r_state == c_st_load) && (r_index < c_depth);
  assign w_accept = bus.in_valid && w_ready;
  assign w_start  = bus.go && ((r_state == c_st_idle) || (r_state == c_st_done));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= c_st_idle;
      r_index    <= '0;
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data1    <= '0;
      r_data2    <= '0;
      r_length   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_state    <= c_st_load;
        r_index    <= '0;
        r_done     <= 1'b0;
        r_length   <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        r_we    <= 1'b1;
        r_addr  <= r_index;
        r_data1 <= bus.in_a;
        r_data2 <= bus.in_b;
        r_index <= r_index + 17'd1;
        // in_last wins over the full condition: a list of exactly DEPTH is legal.
        if (bus.in_last) begin
          r_length <= r_index[15:0];
          r_state  <= c_st_done;
          r_done   <= 1'b1;
        end else if (r_index == c_last_idx) begin
          r_overflow <= 1'b1;
          r_length   <= c_last_idx[15:0];
          r_state    <= c_st_done;
          r_done     <= 1'b1;
        end
      end
    end
  end

`ifdef LIST_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] w_mix;
  logic [31:0]       w_mix32;
  logic [31:0]       r_checksum;

  assign w_mix = bus.in_a ^ bus.in_b;

  generate
    if (DATA_W >= 32) begin : g_mix_trunc
      assign w_mix32 = w_mix[31:0];
    end else begin : g_mix_ext
      assign w_mix32 = {{(32 - DATA_W){1'b0}}, w_mix};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum ^ w_mix32;
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = 32'd0;
`endif

  assign bus.in_ready = w_ready;
  assign bus.done     = r_done;
  assign bus.we1      = r_we;
  assign bus.we2      = r_we;
  assign bus.addr1    = {15'd0, r_addr};
  assign bus.addr2    = {15'd0, r_addr};
  assign bus.data1_in = r_data1;
  assign bus.data2_in = r_data2;
  assign bus.length   = r_length;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_list_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_list_loader
// Purpose  : Directed self-checking bench for list_loader (DEPTH = 4).
// Revision : 1.0
// ============================================================================
module tb_list_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  list_loader_if #(.DATA_W(DW)) bus ();

  list_loader #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] a;
    logic [31:0] b;
    bit          fin;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] pa[8];
  logic [31:0] pb[8];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Every write must match the next expected (address, a, b); done rises only with the final one.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.we1 === 1'b1 || bus.we2 === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_write: we1=%0b we2=%0b addr1=0x%08h with no write expected",
                   bus.we1, bus.we2, bus.addr1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("we1", 32'(bus.we1), 32'd1);
          chk("we2", 32'(bus.we2), 32'd1);
          chk("addr1", bus.addr1, e.addr);
          chk("addr2", bus.addr2, e.addr);
          chk("data1_in", bus.data1_in, e.a);
          chk("data2_in", bus.data2_in, e.b);
          chk("done_with_write", 32'(bus.done), 32'(e.fin));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_done"},     32'(bus.done),     32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_we1"},      32'(bus.we1),      32'd0);
    chk({tag, "_we2"},      32'(bus.we2),      32'd0);
    chk({tag, "_addr1"},    bus.addr1,         32'd0);
    chk({tag, "_addr2"},    bus.addr2,         32'd0);
    chk({tag, "_data1"},    bus.data1_in,      32'd0);
    chk({tag, "_data2"},    bus.data2_in,      32'd0);
    chk({tag, "_length"},   32'(bus.length),   32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_checksum"}, bus.checksum,      32'd0);
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    chk("go_done_cleared",     32'(bus.done),     32'd0);
    chk("go_length_cleared",   32'(bus.length),   32'd0);
    chk("go_overflow_cleared", 32'(bus.overflow), 32'd0);
    chk("go_checksum_cleared", bus.checksum,      32'd0);
    chk("go_in_ready",         32'(bus.in_ready), 32'd1);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                           input bit last, input bit expect_acc);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    for (int t = 0; t < 8 && !acc; t++) begin
      if (bus.in_ready === 1'b1) acc = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("pair_accepted", 32'(acc), 32'(expect_acc));
  endtask

  // Model: the first min(n, DEPTH) pairs land at 0.., length is the last index written,
  // overflow when more pairs than DEPTH were offered, checksum XORs the accepted pairs.
  task automatic load(input int n, input int gap);
    int          n_acc;
    logic [31:0] cks;
    n_acc = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    cks   = 32'd0;
    for (int i = 0; i < n_acc; i++) begin
      exp_q.push_back('{addr: 32'(i), a: pa[i], b: pb[i], fin: (i == n_acc - 1)});
      cks ^= pa[i] ^ pb[i];
    end
`ifndef LIST_LOADER_CHECKSUM_EN
    cks = 32'd0;
`endif
    pulse_go();
    for (int i = 0; i < n; i++) begin
      send_pair(pa[i], pb[i], (i == n - 1), (i < int'(DEPTH)));
      repeat (gap) @(negedge clk);
    end
    @(negedge clk);
    chk("load_done",       32'(bus.done),       32'd1);
    chk("load_length",     32'(bus.length),     32'(n_acc - 1));
    chk("load_overflow",   32'(bus.overflow),   32'(n > int'(DEPTH)));
    chk("load_checksum",   bus.checksum,        cks);
    chk("load_in_ready",   32'(bus.in_ready),   32'd0);
    chk("load_writes_left", 32'(exp_q.size()),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.go       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_last  = 1'b0;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset  = 1'b1;
    mon_en = 1'b1;

    // Offered pairs while idle must not be taken.
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h0000_DEAD;
    bus.in_b     = 32'h1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // Basic load.
    pa[0] = 32'd3; pb[0] = 32'd4;
    pa[1] = 32'd4; pb[1] = 32'd3;
    pa[2] = 32'd2; pb[2] = 32'd5;
    load(3, 0);
    chk("basic_length_lit",   32'(bus.length),   32'd2);
    chk("basic_overflow_lit", 32'(bus.overflow), 32'd0);

    // Restart from DONE, same pairs with two idle cycles between them.
    load(3, 2);
    chk("gap_length_lit", 32'(bus.length), 32'd2);

    // Overflow: five pairs offered into four entries.
    for (int i = 0; i < 5; i++) begin
      pa[i] = 32'(10 + 2 * i);
      pb[i] = 32'(11 + 2 * i);
    end
    load(5, 0);
    chk("ovf_length_lit",   32'(bus.length),   32'd3);
    chk("ovf_overflow_lit", 32'(bus.overflow), 32'd1);

    // Reset mid-load; go held during the second pair must be ignored.
    pulse_go();
    exp_q.push_back('{addr: 32'd0, a: 32'd7, b: 32'd1, fin: 1'b0});
    exp_q.push_back('{addr: 32'd1, a: 32'd9, b: 32'd2, fin: 1'b0});
    send_pair(32'd7, 32'd1, 1'b0, 1'b1);
    bus.go = 1'b1;
    send_pair(32'd9, 32'd2, 1'b0, 1'b1);
    bus.go = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_idle_ready", 32'(bus.in_ready), 32'd0);
    chk("midreset_writes_left", 32'(exp_q.size()), 32'd0);

    // Single pair after reset.
    pa[0] = 32'd5; pb[0] = 32'd6;
    load(1, 0);
    chk("single_length_lit", 32'(bus.length), 32'd0);

    // Checksum pair set: (1^2)^(4^8) = 15.
    pa[0] = 32'd1; pb[0] = 32'd2;
    pa[1] = 32'd4; pb[1] = 32'd8;
    load(2, 0);
`ifdef LIST_LOADER_CHECKSUM_EN
    chk("checksum_lit", bus.checksum, 32'd15);
`else
    chk("checksum_lit", bus.checksum, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
